// File: rtl/reg_file_pkg.sv
// Shared register-file parameters and helpers, imported by the register file
// and the CPU decode/writeback stages.
package reg_file_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned REG_ZERO   = 0;

  function automatic int unsigned num_regs(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/reg_file_fwd_scoreboard.sv
// Pending-load scoreboard: one bit per register, busy masking for loads that
// complete this cycle, and a registered count of pending registers.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  input  logic              wr_en_b,
  input  logic [ADDR_W-1:0] wr_addr_b,
  input  logic              reserve_en,
  input  logic [ADDR_W-1:0] reserve_addr,
  output logic              busy1,
  output logic              busy2,
  output logic [ADDR_W:0]   pending_cnt
);

  localparam int unsigned NUM_REGS = num_regs(ADDR_W);

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;
  logic                res_ok;
  logic                set_new;
  logic                clr_real;

  always_comb begin
    res_ok   = reserve_en && !(ZERO_REG && reserve_addr == ADDR_W'(REG_ZERO));
    set_mask = '0;
    clr_mask = '0;
    if (res_ok)  set_mask = NUM_REGS'(1) << reserve_addr;
    if (wr_en_b) clr_mask = NUM_REGS'(1) << wr_addr_b;
    set_new  = res_ok && !pending[reserve_addr];
    // A same-address reserve re-arms the bit, so that clear does not count.
    clr_real = wr_en_b && pending[wr_addr_b] &&
               !(res_ok && reserve_addr == wr_addr_b);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending     <= '0;
      pending_cnt <= '0;
    end else begin
      pending     <= (pending & ~clr_mask) | set_mask;
      pending_cnt <= pending_cnt + (ADDR_W+1)'(set_new) - (ADDR_W+1)'(clr_real);
    end
  end

  assign busy1 = pending[read_reg1] & ~(wr_en_b && wr_addr_b == read_reg1);
  assign busy2 = pending[read_reg2] & ~(wr_en_b && wr_addr_b == read_reg2);

endmodule

// File: rtl/reg_file_fwd.sv
// Two-read / two-write register file with same-cycle write forwarding and a
// pending-load scoreboard. Port B (load) wins write collisions.
module reg_file_fwd
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic              busy1,
  output logic              busy2,
  input  logic              wr_en_a,
  input  logic [ADDR_W-1:0] wr_addr_a,
  input  logic [DATA_W-1:0] wr_data_a,
  input  logic              wr_en_b,
  input  logic [ADDR_W-1:0] wr_addr_b,
  input  logic [DATA_W-1:0] wr_data_b,
  input  logic              reserve_en,
  input  logic [ADDR_W-1:0] reserve_addr,
  output logic [ADDR_W:0]   pending_cnt
);

  localparam int unsigned NUM_REGS = num_regs(ADDR_W);
  localparam logic [ADDR_W-1:0] R0 = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              we_a;
  logic              we_b;

  assign we_a = wr_en_a && !(ZERO_REG && wr_addr_a == R0);
  assign we_b = wr_en_b && !(ZERO_REG && wr_addr_b == R0);

  // Port B is written last so it overrides port A on an address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '{default: '0};
    end else begin
      if (we_a) regs[wr_addr_a] <= wr_data_a;
      if (we_b) regs[wr_addr_b] <= wr_data_b;
    end
  end

  always_comb begin
    read_data1 = regs[read_reg1];
    if (ZERO_REG && read_reg1 == R0)              read_data1 = '0;
    else if (wr_en_b && wr_addr_b == read_reg1)   read_data1 = wr_data_b;
    else if (wr_en_a && wr_addr_a == read_reg1)   read_data1 = wr_data_a;
  end

  always_comb begin
    read_data2 = regs[read_reg2];
    if (ZERO_REG && read_reg2 == R0)              read_data2 = '0;
    else if (wr_en_b && wr_addr_b == read_reg2)   read_data2 = wr_data_b;
    else if (wr_en_a && wr_addr_a == read_reg2)   read_data2 = wr_data_a;
  end

  reg_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .read_reg1    (read_reg1),
    .read_reg2    (read_reg2),
    .wr_en_b      (wr_en_b),
    .wr_addr_b    (wr_addr_b),
    .reserve_en   (reserve_en),
    .reserve_addr (reserve_addr),
    .busy1        (busy1),
    .busy2        (busy2),
    .pending_cnt  (pending_cnt)
  );

endmodule

// File: tb/tb_reg_file_fwd.sv
// Directed self-checking bench for reg_file_fwd (default 16x16, ZERO_REG=1).
module tb_reg_file_fwd;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  read_reg1, read_reg2;
  logic [15:0] read_data1, read_data2;
  logic        busy1, busy2;
  logic        wr_en_a, wr_en_b, reserve_en;
  logic [3:0]  wr_addr_a, wr_addr_b, reserve_addr;
  logic [15:0] wr_data_a, wr_data_b;
  logic [4:0]  pending_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_file_fwd #(
    .DATA_W   (16),
    .ADDR_W   (4),
    .ZERO_REG (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .read_reg1    (read_reg1),
    .read_reg2    (read_reg2),
    .read_data1   (read_data1),
    .read_data2   (read_data2),
    .busy1        (busy1),
    .busy2        (busy2),
    .wr_en_a      (wr_en_a),
    .wr_addr_a    (wr_addr_a),
    .wr_data_a    (wr_data_a),
    .wr_en_b      (wr_en_b),
    .wr_addr_b    (wr_addr_b),
    .wr_data_b    (wr_data_b),
    .reserve_en   (reserve_en),
    .reserve_addr (reserve_addr),
    .pending_cnt  (pending_cnt)
  );

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en_a = 0; wr_addr_a = 0; wr_data_a = 0;
    wr_en_b = 0; wr_addr_b = 0; wr_data_b = 0;
    reserve_en = 0; reserve_addr = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs(); read_reg1 = 0; read_reg2 = 0;
    step();
    step();
    rst = 0;
    for (int i = 0; i < 16; i++) begin
      read_reg1 = 4'(i); read_reg2 = 4'(15 - i);
      #1;
      checks++;
      if (read_data1 !== 16'h0 || read_data2 !== 16'h0) begin
        errors++;
        $display("FAIL reset_data[%0d]: got %h/%h, expected 0000/0000", i, read_data1, read_data2);
      end
      checks++;
      if (busy1 !== 1'b0 || busy2 !== 1'b0) begin
        errors++;
        $display("FAIL reset_busy[%0d]: got %b/%b, expected 0/0", i, busy1, busy2);
      end
    end
    checks++;
    if (pending_cnt !== 5'd0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d, expected 0", pending_cnt);
    end
  endtask

  task automatic test_forward_a();
    idle_inputs();
    wr_en_a = 1; wr_addr_a = 5; wr_data_a = 16'h1234; read_reg1 = 5;
    #1;
    checks++;
    if (read_data1 !== 16'h1234) begin
      errors++;
      $display("FAIL fwd_a_same_cycle: got %h, expected 1234", read_data1);
    end
    step();
    idle_inputs();
    #1;
    checks++;
    if (read_data1 !== 16'h1234) begin
      errors++;
      $display("FAIL fwd_a_stored: got %h, expected 1234", read_data1);
    end
  endtask

  task automatic test_collision();
    idle_inputs();
    wr_en_a = 1; wr_addr_a = 7; wr_data_a = 16'hAAAA;
    wr_en_b = 1; wr_addr_b = 7; wr_data_b = 16'h5555;
    read_reg2 = 7;
    #1;
    checks++;
    if (read_data2 !== 16'h5555) begin
      errors++;
      $display("FAIL collision_fwd: got %h, expected 5555", read_data2);
    end
    step();
    idle_inputs();
    #1;
    checks++;
    if (read_data2 !== 16'h5555) begin
      errors++;
      $display("FAIL collision_stored: got %h, expected 5555", read_data2);
    end
  endtask

  task automatic test_scoreboard();
    idle_inputs();
    reserve_en = 1; reserve_addr = 3; read_reg1 = 3;
    #1;
    checks++;
    if (busy1 !== 1'b0 || pending_cnt !== 5'd0) begin
      errors++;
      $display("FAIL sb_reserve_cycle: got busy=%b cnt=%0d, expected busy=0 cnt=0", busy1, pending_cnt);
    end
    step();
    idle_inputs();
    #1;
    checks++;
    if (busy1 !== 1'b1 || pending_cnt !== 5'd1) begin
      errors++;
      $display("FAIL sb_pending: got busy=%b cnt=%0d, expected busy=1 cnt=1", busy1, pending_cnt);
    end
    wr_en_b = 1; wr_addr_b = 3; wr_data_b = 16'h00FF;
    #1;
    checks++;
    if (busy1 !== 1'b0 || read_data1 !== 16'h00FF || pending_cnt !== 5'd1) begin
      errors++;
      $display("FAIL sb_load_cycle: got busy=%b data=%h cnt=%0d, expected busy=0 data=00ff cnt=1", busy1, read_data1, pending_cnt);
    end
    step();
    idle_inputs();
    #1;
    checks++;
    if (busy1 !== 1'b0 || read_data1 !== 16'h00FF || pending_cnt !== 5'd0) begin
      errors++;
      $display("FAIL sb_after_load: got busy=%b data=%h cnt=%0d, expected busy=0 data=00ff cnt=0", busy1, read_data1, pending_cnt);
    end
  endtask

  task automatic test_zero_reg();
    idle_inputs();
    wr_en_a = 1; wr_addr_a = 0; wr_data_a = 16'hFFFF;
    wr_en_b = 1; wr_addr_b = 0; wr_data_b = 16'hFFFF;
    reserve_en = 1; reserve_addr = 0;
    read_reg1 = 0; read_reg2 = 0;
    #1;
    checks++;
    if (read_data1 !== 16'h0 || read_data2 !== 16'h0) begin
      errors++;
      $display("FAIL zero_fwd: got %h/%h, expected 0000/0000", read_data1, read_data2);
    end
    step();
    idle_inputs();
    #1;
    checks++;
    if (read_data1 !== 16'h0 || busy1 !== 1'b0 || pending_cnt !== 5'd0) begin
      errors++;
      $display("FAIL zero_after: got data=%h busy=%b cnt=%0d, expected data=0000 busy=0 cnt=0", read_data1, busy1, pending_cnt);
    end
  endtask

  task automatic test_reserve_edges();
    idle_inputs();
    read_reg2 = 6;
    // Reserve and load-complete on the same register: reserve wins.
    reserve_en = 1; reserve_addr = 6;
    wr_en_b = 1; wr_addr_b = 6; wr_data_b = 16'h0606;
    step();
    idle_inputs();
    #1;
    checks++;
    if (busy2 !== 1'b1 || pending_cnt !== 5'd1 || read_data2 !== 16'h0606) begin
      errors++;
      $display("FAIL res_clr_same: got busy=%b cnt=%0d data=%h, expected busy=1 cnt=1 data=0606", busy2, pending_cnt, read_data2);
    end
    reserve_en = 1; reserve_addr = 6;
    step();
    idle_inputs();
    #1;
    checks++;
    if (busy2 !== 1'b1 || pending_cnt !== 5'd1) begin
      errors++;
      $display("FAIL double_reserve: got busy=%b cnt=%0d, expected busy=1 cnt=1", busy2, pending_cnt);
    end
    wr_en_b = 1; wr_addr_b = 9; wr_data_b = 16'h0909;
    step();
    idle_inputs();
    #1;
    checks++;
    if (pending_cnt !== 5'd1) begin
      errors++;
      $display("FAIL clear_nonpending: got cnt=%0d, expected 1", pending_cnt);
    end
    // Port A must not clear a pending bit.
    wr_en_a = 1; wr_addr_a = 6; wr_data_a = 16'h7777;
    step();
    idle_inputs();
    #1;
    checks++;
    if (busy2 !== 1'b1 || pending_cnt !== 5'd1 || read_data2 !== 16'h7777) begin
      errors++;
      $display("FAIL port_a_no_clear: got busy=%b cnt=%0d data=%h, expected busy=1 cnt=1 data=7777", busy2, pending_cnt, read_data2);
    end
    wr_en_b = 1; wr_addr_b = 6; wr_data_b = 16'h1111;
    step();
    idle_inputs();
    #1;
    checks++;
    if (busy2 !== 1'b0 || pending_cnt !== 5'd0 || read_data2 !== 16'h1111) begin
      errors++;
      $display("FAIL clear_pending: got busy=%b cnt=%0d data=%h, expected busy=0 cnt=0 data=1111", busy2, pending_cnt, read_data2);
    end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    wr_en_a = 1; wr_addr_a = 1; wr_data_a = 16'h4321;
    step();
    idle_inputs();
    reserve_en = 1; reserve_addr = 1; step();
    reserve_addr = 2; step();
    reserve_addr = 4; step();
    idle_inputs();
    read_reg1 = 2; read_reg2 = 4;
    #1;
    checks++;
    if (pending_cnt !== 5'd3 || busy1 !== 1'b1 || busy2 !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: got cnt=%0d busy=%b/%b, expected cnt=3 busy=1/1", pending_cnt, busy1, busy2);
    end
    rst = 1;
    wr_en_a = 1; wr_addr_a = 1; wr_data_a = 16'h9999;
    reserve_en = 1; reserve_addr = 5;
    step();
    rst = 0;
    idle_inputs();
    read_reg1 = 1; read_reg2 = 5;
    #1;
    checks++;
    if (read_data1 !== 16'h0 || busy1 !== 1'b0 || busy2 !== 1'b0 || pending_cnt !== 5'd0) begin
      errors++;
      $display("FAIL reset_mid_a: got data=%h busy=%b/%b cnt=%0d, expected 0000 0/0 0", read_data1, busy1, busy2, pending_cnt);
    end
    read_reg1 = 2; read_reg2 = 4;
    #1;
    checks++;
    if (busy1 !== 1'b0 || busy2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_b: got busy=%b/%b, expected 0/0", busy1, busy2);
    end
  endtask

  initial begin
    test_reset();
    test_forward_a();
    test_collision();
    test_scoreboard();
    test_zero_reg();
    test_reserve_edges();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
